// File: rtl/main_mem_responder.sv
// Line-granular main-memory responder with a single outstanding request.
// A request is accepted in IDLE, waits a fixed per-direction latency, then
// presents a single-beat response held stable until it is consumed.
// Storage has no reset; control, response and counters reset asynchronously.

package mem_pkg;
  localparam int XLEN                    = 32;
  localparam int DEFAULT_CACHE_LINE_SIZE = 16;
endpackage

// Request/response channel between a memory requester and a responder.
interface memory_req_rsp_if #(
  parameter int XLEN       = mem_pkg::XLEN,
  parameter int LINE_BYTES = mem_pkg::DEFAULT_CACHE_LINE_SIZE
);
  typedef struct packed {
    logic [XLEN-1:0]         addr;
    logic                    write;
    logic [LINE_BYTES*8-1:0] data;
  } req_t;

  typedef struct packed {
    logic [LINE_BYTES*8-1:0] data;
    logic                    last;
    logic                    error;
  } rsp_t;

  logic req_valid;
  logic req_ready;
  req_t req;
  logic rsp_valid;
  logic rsp_ready;
  rsp_t rsp;

  modport slave (
    input  req_valid, req, rsp_ready,
    output req_ready, rsp_valid, rsp
  );

  modport master (
    output req_valid, req, rsp_ready,
    input  req_ready, rsp_valid, rsp
  );
endinterface

// Protocol properties of the responder's outputs.
module main_mem_responder_chk #(
  parameter int LINE_W = 128
) (
  input logic              clk,
  input logic              rst,
  input logic              req_ready,
  input logic              rsp_valid,
  input logic              rsp_ready,
  input logic              rsp_last,
  input logic              rsp_error,
  input logic [LINE_W-1:0] rsp_data
);
  // Single-beat responses: last always tracks valid.
  a_last_tracks_valid: assert property (@(posedge clk) disable iff (rst)
    rsp_last == rsp_valid);

  // Only one transaction in flight: never ready while a response is pending.
  a_ready_excl_valid: assert property (@(posedge clk) disable iff (rst)
    !(req_ready && rsp_valid));

  // A stalled response keeps its payload.
  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_error)));

  // Error responses carry no data.
  a_err_no_data: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && rsp_error) |-> (rsp_data == {LINE_W{1'b0}}));
endmodule

module main_mem_responder
  import mem_pkg::*;
#(
  parameter int              MEM_LINES       = 1024,
  parameter int              CACHE_LINE_SIZE = DEFAULT_CACHE_LINE_SIZE,
  parameter logic [XLEN-1:0] BASE_ADDR       = 32'h0,
  parameter int              RD_LATENCY      = 4,
  parameter int              WR_LATENCY      = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  memory_req_rsp_if.slave        mem_if,
  output logic [31:0]            rd_count_o,
  output logic [31:0]            wr_count_o
);

  localparam int LINE_W  = CACHE_LINE_SIZE * 8;
  localparam int OFF_W   = $clog2(CACHE_LINE_SIZE);
  localparam int IDX_W   = $clog2(MEM_LINES);
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  // Size of the mapped window in bytes, wide enough not to overflow.
  localparam logic [63:0] SPAN = 64'(MEM_LINES) * 64'(CACHE_LINE_SIZE);

  // Counter preload: the accept cycle itself accounts for one cycle of latency.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // Latched request
  logic              wr_r;
  logic              err_r;
  logic [IDX_W-1:0]  idx_r;
  logic [LINE_W-1:0] wdata_r;
  logic [CNT_W-1:0]  lat_r;

  // Response registers
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic [LINE_W-1:0] rsp_data_r;

  // Request counters
  logic [31:0] rd_cnt_r;
  logic [31:0] wr_cnt_r;

  // Line storage, deliberately without reset
  logic [LINE_W-1:0] mem_r [MEM_LINES];

  // Decode of the incoming request
  logic [63:0]       off_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [CNT_W-1:0]  load_s;
  logic              req_ready_s;
  logic              accept_s;
  logic              resp_done_s;
  logic              enter_rsp_s;
  logic              sel_wr_s;
  logic              sel_err_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic              mem_we_s;

  assign off_s      = 64'(mem_if.req.addr) - 64'(BASE_ADDR);
  assign in_range_s = (mem_if.req.addr >= BASE_ADDR) && (off_s < SPAN);
  assign req_idx_s  = off_s[OFF_W +: IDX_W];
  assign load_s     = mem_if.req.write ? WR_LOAD : RD_LOAD;

  // Ready is held low for the whole reset, then rises as soon as it lifts.
  assign req_ready_s = (state_r == S_IDLE) && !rst_i;
  assign accept_s    = req_ready_s && mem_if.req_valid;
  assign resp_done_s = (state_r == S_RESPOND) && mem_if.rsp_ready;
  assign enter_rsp_s = (next_state_s == S_RESPOND) && (state_r != S_RESPOND);

  // With latency 1 RESPOND is entered straight from IDLE, before the request
  // is latched, so the entry logic picks the live request fields in that case.
  assign sel_wr_s  = (state_r == S_IDLE) ? mem_if.req.write : wr_r;
  assign sel_err_s = (state_r == S_IDLE) ? !in_range_s      : err_r;
  assign sel_idx_s = (state_r == S_IDLE) ? req_idx_s        : idx_r;

  // Writes commit at the response handshake, and only for mapped lines.
  assign mem_we_s = resp_done_s && wr_r && !err_r && !rst_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (load_s == {CNT_W{1'b0}}) begin
            next_state_s = S_RESPOND;
          end else begin
            next_state_s = S_WAIT;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (lat_r <= CNT_W'(1)) begin
          next_state_s = S_RESPOND;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_RESPOND: begin
        if (mem_if.rsp_ready) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_RESPOND;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Latch the accepted request and run the latency countdown
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_r    <= 1'b0;
      err_r   <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      wdata_r <= {LINE_W{1'b0}};
      lat_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      wr_r    <= mem_if.req.write;
      err_r   <= !in_range_s;
      idx_r   <= req_idx_s;
      wdata_r <= mem_if.req.data;
      lat_r   <= load_s;
    end else if (state_r == S_WAIT) begin
      lat_r   <= lat_r - CNT_W'(1);
    end
  end

  // Build the response on entry to RESPOND, drop it after the handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= {LINE_W{1'b0}};
    end else if (enter_rsp_s) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= sel_err_s;
      if (!sel_wr_s && !sel_err_s) begin
        rsp_data_r <= mem_r[sel_idx_s];
      end else begin
        rsp_data_r <= {LINE_W{1'b0}};
      end
    end else if (resp_done_s) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= {LINE_W{1'b0}};
    end
  end

  // Line storage write port
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  // Saturating accept counters, errors included
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_r <= 32'h0;
      wr_cnt_r <= 32'h0;
    end else if (accept_s) begin
      if (mem_if.req.write) begin
        if (wr_cnt_r != 32'hFFFF_FFFF) begin
          wr_cnt_r <= wr_cnt_r + 32'd1;
        end
      end else begin
        if (rd_cnt_r != 32'hFFFF_FFFF) begin
          rd_cnt_r <= rd_cnt_r + 32'd1;
        end
      end
    end
  end

  assign mem_if.req_ready = req_ready_s;
  assign mem_if.rsp_valid = rsp_valid_r;
  assign mem_if.rsp       = {rsp_data_r, rsp_valid_r, rsp_err_r};
  assign rd_count_o       = rd_cnt_r;
  assign wr_count_o       = wr_cnt_r;

  main_mem_responder_chk #(
    .LINE_W (LINE_W)
  ) u_chk (
    .clk       (clk_i),
    .rst       (rst_i),
    .req_ready (req_ready_s),
    .rsp_valid (rsp_valid_r),
    .rsp_ready (mem_if.rsp_ready),
    .rsp_last  (rsp_valid_r),
    .rsp_error (rsp_err_r),
    .rsp_data  (rsp_data_r)
  );

endmodule
